// File: rtl/multicore_system_ram_arbiter.sv
// Two-port round-robin Avalon-MM arbiter in front of a single-port, one-cycle-latency RAM.
// Grants at most one transfer per cycle and steers each read return back to its issuer.
module multicore_system_ram_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic req0, req1;
  logic grant0, grant1, any_grant;
  logic prio_q, prio_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // prio_q = 1 favours port 1 when both ports request in the same cycle.
  always_comb begin
    req0      = s0_read | s0_write;
    req1      = s1_read | s1_write;
    grant0    = req0 & (~req1 | ~prio_q);
    grant1    = req1 & (~req0 | prio_q);
    any_grant = grant0 | grant1;

    prio_d = prio_q;
    if (grant0) begin
      prio_d = 1'b1;
    end else if (grant1) begin
      prio_d = 1'b0;
    end

    // Read+write together is a write, so only a pure read leaves a return pending.
    rd_pend_d  = (grant0 & ~s0_write) | (grant1 & ~s1_write);
    rd_owner_d = rd_owner_q;
    if (any_grant) begin
      rd_owner_d = grant1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    ram_address    = s0_address;
    ram_byteenable = s0_byteenable;
    ram_writedata  = s0_writedata;
    ram_write      = 1'b0;
    if (grant1) begin
      ram_address    = s1_address;
      ram_byteenable = s1_byteenable;
      ram_writedata  = s1_writedata;
      ram_write      = s1_write;
    end else if (grant0) begin
      ram_write      = s0_write;
    end
    ram_chipselect = any_grant;
    ram_clken      = 1'b1;
  end

  always_comb begin
    s0_waitrequest   = req0 & ~grant0;
    s1_waitrequest   = req1 & ~grant1;
    s0_readdatavalid = rd_pend_q & ~rd_owner_q;
    s1_readdatavalid = rd_pend_q & rd_owner_q;
    s0_readdata      = ram_readdata;
    s1_readdata      = ram_readdata;
  end

endmodule

// File: tb/tb_multicore_system_ram_arbiter.sv
// Bench for multicore_system_ram_arbiter: directed vector table, reset corner cases and
// randomized traffic checked against a transaction-level model with a shadow memory.
module tb_multicore_system_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  s0_address, s1_address;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicore_system_ram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_byteenable    (s0_byteenable),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // Behavioural 1024x32 byte-enabled RAM with registered read data.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op0, input logic [9:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic [1:0] op1, input logic [9:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    {s0_read, s0_write} = op0;
    s0_address = a0; s0_byteenable = be0; s0_writedata = d0;
    {s1_read, s1_write} = op1;
    s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
  endtask

  task automatic idle();
    drive(2'b00, 10'h0, 4'h0, 32'h0, 2'b00, 10'h0, 4'h0, 32'h0);
  endtask

  // op = {read, write}; flg = {wr0, wr1, v0, v1, cs, rw}; rd = data on the valid port.
  typedef struct {
    logic [1:0]  op0;
    logic [9:0]  a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [1:0]  op1;
    logic [9:0]  a1;
    logic [3:0]  be1;
    logic [31:0] d1;
    logic [5:0]  flg;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [17];

  // Transaction-level reference model state.
  logic [31:0] shadow [1024];
  int          m_prio;
  bit          m_pend;
  int          m_port;
  logic [31:0] m_data;
  logic [1:0]  r_op [2];
  logic [9:0]  r_a  [2];
  logic [3:0]  r_be [2];
  logic [31:0] r_d  [2];
  bit          hold [2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    check("reset cs", ram_chipselect, 1'b0);
    check("reset v0", s0_readdatavalid, 1'b0);
    check("reset v1", s1_readdatavalid, 1'b0);
    check("reset wr0", s0_waitrequest, 1'b0);
    check("reset wr1", s1_waitrequest, 1'b0);
    check("reset clken", ram_clken, 1'b1);
    @(posedge clk); #1;

    tbl[ 0] = '{2'b01, 10'h005, 4'hF, 32'hDEADBEEF, 2'b00, 10'h000, 4'h0, 32'h0, 6'b000011, 32'h0};
    tbl[ 1] = '{2'b10, 10'h005, 4'hF, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b000010, 32'h0};
    tbl[ 2] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b001000, 32'hDEADBEEF};
    tbl[ 3] = '{2'b01, 10'h010, 4'hF, 32'h11111111, 2'b00, 10'h0, 4'h0, 32'h0, 6'b000011, 32'h0};
    tbl[ 4] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b01, 10'h020, 4'hF, 32'h22222222, 6'b000011, 32'h0};
    tbl[ 5] = '{2'b10, 10'h010, 4'hF, 32'h0, 2'b10, 10'h020, 4'hF, 32'h0, 6'b010010, 32'h0};
    tbl[ 6] = '{2'b10, 10'h010, 4'hF, 32'h0, 2'b10, 10'h020, 4'hF, 32'h0, 6'b101010, 32'h11111111};
    tbl[ 7] = '{2'b10, 10'h010, 4'hF, 32'h0, 2'b10, 10'h020, 4'hF, 32'h0, 6'b010110, 32'h22222222};
    tbl[ 8] = '{2'b10, 10'h010, 4'hF, 32'h0, 2'b10, 10'h020, 4'hF, 32'h0, 6'b101010, 32'h11111111};
    tbl[ 9] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b000100, 32'h22222222};
    tbl[10] = '{2'b01, 10'h3FF, 4'hF, 32'hFFFFFFFF, 2'b00, 10'h0, 4'h0, 32'h0, 6'b000011, 32'h0};
    tbl[11] = '{2'b01, 10'h3FF, 4'h1, 32'h000000AB, 2'b00, 10'h0, 4'h0, 32'h0, 6'b000011, 32'h0};
    tbl[12] = '{2'b10, 10'h3FF, 4'hF, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b000010, 32'h0};
    tbl[13] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b001000, 32'hFFFFFFAB};
    tbl[14] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b11, 10'h040, 4'hF, 32'h12345678, 6'b000011, 32'h0};
    tbl[15] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b10, 10'h040, 4'hF, 32'h0, 6'b000010, 32'h0};
    tbl[16] = '{2'b00, 10'h000, 4'h0, 32'h0, 2'b00, 10'h000, 4'h0, 32'h0, 6'b000100, 32'h12345678};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].op0, tbl[i].a0, tbl[i].be0, tbl[i].d0,
            tbl[i].op1, tbl[i].a1, tbl[i].be1, tbl[i].d1);
      @(negedge clk);
      check($sformatf("vec%0d wr0", i), s0_waitrequest, tbl[i].flg[5]);
      check($sformatf("vec%0d wr1", i), s1_waitrequest, tbl[i].flg[4]);
      check($sformatf("vec%0d v0", i), s0_readdatavalid, tbl[i].flg[3]);
      check($sformatf("vec%0d v1", i), s1_readdatavalid, tbl[i].flg[2]);
      check($sformatf("vec%0d cs", i), ram_chipselect, tbl[i].flg[1]);
      check($sformatf("vec%0d rw", i), ram_write, tbl[i].flg[0]);
      if (tbl[i].flg[3]) check($sformatf("vec%0d rd0", i), s0_readdata, tbl[i].rd);
      if (tbl[i].flg[2]) check($sformatf("vec%0d rd1", i), s1_readdata, tbl[i].rd);
      @(posedge clk); #1;
    end

    // Reset lands while an s0 read is granted but before it is clocked; prio was 1.
    drive(2'b01, 10'h006, 4'hF, 32'h0, 2'b00, 10'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    drive(2'b10, 10'h005, 4'hF, 32'h0, 2'b00, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("mid-read grant", s0_waitrequest, 1'b0);
    reset_n = 1'b0;
    #1 idle();
    @(posedge clk); #1;
    check("mid-read v0 in reset", s0_readdatavalid, 1'b0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(negedge clk);
    check("post-reset v0", s0_readdatavalid, 1'b0);
    check("post-reset v1", s1_readdatavalid, 1'b0);
    @(posedge clk); #1;
    drive(2'b10, 10'h005, 4'hF, 32'h0, 2'b10, 10'h020, 4'hF, 32'h0);
    @(negedge clk);
    check("post-reset first grant wr0", s0_waitrequest, 1'b0);
    check("post-reset first grant wr1", s1_waitrequest, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset v0", s0_readdatavalid, 1'b1);
    check("post-reset rd0", s0_readdata, 32'hDEADBEEF);
    check("post-reset second grant wr0", s0_waitrequest, 1'b1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("post-reset v1", s1_readdatavalid, 1'b1);
    check("post-reset rd1", s1_readdata, 32'h22222222);
    @(posedge clk); #1;

    // A return already in flight must vanish as soon as reset asserts.
    drive(2'b00, 10'h0, 4'h0, 32'h0, 2'b10, 10'h010, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("async v1 before", s1_readdatavalid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async v1 dropped", s1_readdatavalid, 1'b0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic on a region the directed tests never touch.
    m_prio = 0;
    m_pend = 0;
    m_port = 0;
    m_data = 32'h0;
    for (int p = 0; p < 2; p++) hold[p] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      bit rq [2];
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          int k = $urandom_range(0, 9);
          r_op[p] = (k < 3) ? 2'b00 : (k < 6) ? 2'b10 : (k < 9) ? 2'b01 : 2'b11;
          r_a[p]  = 10'h100 + 10'($urandom_range(0, 15));
          r_be[p] = 4'($urandom_range(0, 15));
          r_d[p]  = $urandom;
        end
        rq[p] = (r_op[p] != 2'b00);
      end
      drive(r_op[0], r_a[0], r_be[0], r_d[0], r_op[1], r_a[1], r_be[1], r_d[1]);
      if (rq[0] && rq[1]) g = m_prio;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      else g = -1;
      @(negedge clk);
      check("rnd wr0", s0_waitrequest, rq[0] && g != 0);
      check("rnd wr1", s1_waitrequest, rq[1] && g != 1);
      check("rnd v0", s0_readdatavalid, m_pend && m_port == 0);
      check("rnd v1", s1_readdatavalid, m_pend && m_port == 1);
      if (m_pend && m_port == 0) check("rnd rd0", s0_readdata, m_data);
      if (m_pend && m_port == 1) check("rnd rd1", s1_readdata, m_data);
      check("rnd cs", ram_chipselect, g >= 0);
      check("rnd addr", ram_address, (g >= 0) ? r_a[g] : r_a[0]);
      if (g >= 0) check("rnd rw", ram_write, r_op[g][0]);
      m_pend = 0;
      if (g >= 0) begin
        if (r_op[g][0]) begin
          for (int b = 0; b < 4; b++)
            if (r_be[g][b]) shadow[r_a[g]][8*b +: 8] = r_d[g][8*b +: 8];
        end else begin
          m_pend = 1;
          m_port = g;
          m_data = shadow[r_a[g]];
        end
        m_prio = 1 - g;
      end
      for (int p = 0; p < 2; p++) hold[p] = rq[p] && g != p;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
